crypto_ctrl_core: RTL and testbench

Parametrised fetch/decode/execute controller for the cryptography processor. It holds a unified instruction/data memory that is loaded through a manual write port. After reset it executes the stored program: immediate loads into operand registers A and B, memory stores, and encrypt/decrypt operations. Encrypt and decrypt are dispatched to an external ALU over a start/done handshake with a timeout, and the result is written to C.

---
 rtl/crypto_ctrl_core.sv | 264 ++++++++++++++++++++++++++
 tb/tb_crypto_ctrl_core.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crypto_ctrl_core.sv
// -----------------------------------------------------------------------------
// crypto_ctrl_core
// Fetch/decode/execute controller for the cryptography processor. It holds a
// unified instruction/data memory that is filled through a manual write port,
// then runs the stored program. The program can load immediates into A and B,
// store to memory, and run encrypt/decrypt on an external ALU. The ALU is
// driven over a start/done handshake with a timeout, and its result goes to C.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   c_data_in         manual write data
//   c_addr_in         manual write address
//   manual_we         manual write enable; also freezes the FSM
//   alu_res_in        ALU result, valid while alu_done=1
//   alu_done          ALU completion strobe (only honoured in WAIT)
//   alu_start         one-cycle ALU launch pulse (high during START)
//   alu_mode          0 = encrypt, 1 = decrypt; valid START through WAIT
//   c_out_A/B/C       register contents
//   c_we              one-cycle pulse after a core memory write
//   c_addr_out        address of the last core memory write
//   c_data_out        data of the last core memory write
//   pc                program counter
//   halted            FSM is in HALT
//   err               sticky fault (illegal opcode or ALU timeout)
// -----------------------------------------------------------------------------
module crypto_ctrl_core #(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 8,
   parameter int ALU_TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] c_data_in,
   input  logic [ADDR_W-1:0] c_addr_in,
   input  logic              manual_we,
   input  logic [DATA_W-1:0] alu_res_in,
   input  logic              alu_done,
   output logic              alu_start,
   output logic              alu_mode,
   output logic [DATA_W-1:0] c_out_A,
   output logic [DATA_W-1:0] c_out_B,
   output logic [DATA_W-1:0] c_out_C,
   output logic              c_we,
   output logic [ADDR_W-1:0] c_addr_out,
   output logic [DATA_W-1:0] c_data_out,
   output logic [ADDR_W-1:0] pc,
   output logic              halted,
   output logic              err
);

   localparam int DEPTH = 2 ** ADDR_W;
   // The counter holds 0 .. ALU_TIMEOUT-1, which is one value per WAIT cycle.
   localparam int CNT_W = (ALU_TIMEOUT > 1) ? $clog2(ALU_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_TIMEOUT - 1);

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_STI = 4'h1;
   localparam logic [3:0] OP_LDA = 4'h2;
   localparam logic [3:0] OP_LDB = 4'h3;
   localparam logic [3:0] OP_ENC = 4'h6;
   localparam logic [3:0] OP_DEC = 4'h7;
   localparam logic [3:0] OP_STC = 4'h8;
   localparam logic [3:0] OP_HLT = 4'hF;

   typedef enum logic [2:0] {
      ST_FETCH = 3'd0,
      ST_OPND1 = 3'd1,
      ST_OPND2 = 3'd2,
      ST_START = 3'd3,
      ST_WAIT  = 3'd4,
      ST_HALT  = 3'd5
   } state_t;

   state_t             state;
   state_t             nxt;
   logic [DATA_W-1:0]  mem [DEPTH];
   logic [DATA_W-1:0]  word;
   logic [3:0]         word_op;
   logic [3:0]         ir;          // opcode field of the fetched instruction
   logic [ADDR_W-1:0]  sti_addr;
   logic [CNT_W-1:0]   cnt;

   logic               pc_inc;
   logic               ir_ld;
   logic               ld_a;
   logic               ld_b;
   logic               ld_c;
   logic               addr_ld;
   logic               core_we;
   logic [ADDR_W-1:0]  wr_addr;
   logic [DATA_W-1:0]  wr_data;
   logic               cnt_clr;
   logic               cnt_inc;
   logic               err_set;

   // Combinational memory read at the program counter.
   assign word    = mem[pc];
   assign word_op = word[DATA_W-1 -: 4];

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_FETCH;
      end else begin
         state <= nxt;
      end
   end

   // Next-state and datapath control decode.
   always_comb begin
      nxt     = state;
      pc_inc  = 1'b0;
      ir_ld   = 1'b0;
      ld_a    = 1'b0;
      ld_b    = 1'b0;
      ld_c    = 1'b0;
      addr_ld = 1'b0;
      core_we = 1'b0;
      wr_addr = {ADDR_W{1'b0}};
      wr_data = {DATA_W{1'b0}};
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      err_set = 1'b0;
      if (manual_we) begin
         // A manual write freezes everything, so core and manual writes
         // can never collide on the memory port.
         nxt = state;
      end else begin
         case (state)
            ST_FETCH: begin
               ir_ld  = 1'b1;
               pc_inc = 1'b1;
               case (word_op)
                  OP_NOP:                         nxt = ST_FETCH;
                  OP_STI, OP_LDA, OP_LDB, OP_STC: nxt = ST_OPND1;
                  OP_ENC, OP_DEC:                 nxt = ST_START;
                  OP_HLT:                         nxt = ST_HALT;
                  default: begin
                     nxt     = ST_HALT;
                     err_set = 1'b1;
                  end
               endcase
            end
            ST_OPND1: begin
               pc_inc = 1'b1;
               nxt    = ST_FETCH;
               case (ir)
                  OP_LDA: ld_a = 1'b1;
                  OP_LDB: ld_b = 1'b1;
                  OP_STI: begin
                     addr_ld = 1'b1;
                     nxt     = ST_OPND2;
                  end
                  OP_STC: begin
                     core_we = 1'b1;
                     wr_addr = word[ADDR_W-1:0];
                     wr_data = c_out_C;
                  end
                  default: nxt = ST_FETCH;
               endcase
            end
            ST_OPND2: begin
               pc_inc  = 1'b1;
               core_we = 1'b1;
               wr_addr = sti_addr;
               wr_data = word;
               nxt     = ST_FETCH;
            end
            ST_START: begin
               cnt_clr = 1'b1;
               nxt     = ST_WAIT;
            end
            ST_WAIT: begin
               if (alu_done) begin
                  ld_c = 1'b1;
                  nxt  = ST_FETCH;
               end else if (cnt == CNT_LAST) begin
                  // This was WAIT cycle ALU_TIMEOUT without a done.
                  nxt     = ST_HALT;
                  err_set = 1'b1;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
            ST_HALT: nxt = ST_HALT;
            default: begin
               nxt     = ST_HALT;
               err_set = 1'b1;
            end
         endcase
      end
   end

   // Datapath registers and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc         <= {ADDR_W{1'b0}};
         ir         <= 4'h0;
         c_out_A    <= {DATA_W{1'b0}};
         c_out_B    <= {DATA_W{1'b0}};
         c_out_C    <= {DATA_W{1'b0}};
         sti_addr   <= {ADDR_W{1'b0}};
         cnt        <= {CNT_W{1'b0}};
         c_we       <= 1'b0;
         c_addr_out <= {ADDR_W{1'b0}};
         c_data_out <= {DATA_W{1'b0}};
         alu_start  <= 1'b0;
         alu_mode   <= 1'b0;
         halted     <= 1'b0;
         err        <= 1'b0;
      end else begin
         c_we      <= core_we;
         // Registered from the next state so the pulse coincides with START.
         alu_start <= (nxt == ST_START);
         halted    <= (nxt == ST_HALT);
         if (err_set) begin
            err <= 1'b1;
         end
         if (pc_inc) begin
            pc <= pc + ADDR_W'(1);
         end
         if (ir_ld) begin
            ir       <= word_op;
            alu_mode <= (word_op == OP_DEC);
         end else if ((state == ST_WAIT) && (nxt != ST_WAIT)) begin
            alu_mode <= 1'b0;
         end
         if (ld_a) begin
            c_out_A <= word;
         end
         if (ld_b) begin
            c_out_B <= word;
         end
         if (ld_c) begin
            c_out_C <= alu_res_in;
         end
         if (addr_ld) begin
            sti_addr <= word[ADDR_W-1:0];
         end
         if (cnt_clr) begin
            cnt <= {CNT_W{1'b0}};
         end else if (cnt_inc) begin
            cnt <= cnt + CNT_W'(1);
         end
         if (core_we) begin
            c_addr_out <= wr_addr;
            c_data_out <= wr_data;
         end
      end
   end

   // Memory write port; contents survive reset, and no write happens in a
   // reset cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (manual_we) begin
            mem[c_addr_in] <= c_data_in;
         end else if (core_we) begin
            mem[wr_addr] <= wr_data;
         end
      end
   end

endmodule

// File: tb/tb_crypto_ctrl_core.sv
// -----------------------------------------------------------------------------
// tb_crypto_ctrl_core
// Self-checking bench for crypto_ctrl_core. Main instance: DATA_W=8, ADDR_W=8,
// ALU_TIMEOUT=4. A second instance with ADDR_W=4 covers pc wrap-around.
// Expected core writes and ALU launch modes are queued when a program is
// loaded, and they are popped when the DUT pulses c_we / alu_start.
// -----------------------------------------------------------------------------
module tb_crypto_ctrl_core;

   logic       clk        = 1'b0;
   logic       rst        = 1'b1;
   logic [7:0] c_data_in  = 8'h00;
   logic [7:0] c_addr_in  = 8'h00;
   logic       manual_we  = 1'b0;
   logic [7:0] alu_res_in;
   logic       alu_done   = 1'b0;
   logic       alu_start;
   logic       alu_mode;
   logic [7:0] c_out_A;
   logic [7:0] c_out_B;
   logic [7:0] c_out_C;
   logic       c_we;
   logic [7:0] c_addr_out;
   logic [7:0] c_data_out;
   logic [7:0] pc;
   logic       halted;
   logic       err;

   logic       w_rst       = 1'b1;
   logic [7:0] w_data_in   = 8'h00;
   logic [3:0] w_addr_in   = 4'h0;
   logic       w_manual_we = 1'b0;
   logic       w_alu_start;
   logic       w_alu_mode;
   logic [7:0] w_A;
   logic [7:0] w_B;
   logic [7:0] w_C;
   logic       w_c_we;
   logic [3:0] w_addr_out;
   logic [7:0] w_data_out;
   logic [3:0] w_pc;
   logic       w_halted;
   logic       w_err;

   int checks   = 0;
   int failures = 0;

   // ALU model controls
   int         alu_delay = 9999;   // WAIT cycle on which done is raised
   int         wcnt      = -1;
   logic       alu_xor   = 1'b1;
   logic [7:0] alu_const = 8'h00;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } wr_t;

   wr_t        wr_q[$];
   logic       mode_q[$];
   logic [7:0] prog_q[$];

   crypto_ctrl_core #(.DATA_W(8), .ADDR_W(8), .ALU_TIMEOUT(4)) u_dut (
      .clk(clk), .rst(rst), .c_data_in(c_data_in), .c_addr_in(c_addr_in),
      .manual_we(manual_we), .alu_res_in(alu_res_in), .alu_done(alu_done),
      .alu_start(alu_start), .alu_mode(alu_mode), .c_out_A(c_out_A),
      .c_out_B(c_out_B), .c_out_C(c_out_C), .c_we(c_we),
      .c_addr_out(c_addr_out), .c_data_out(c_data_out), .pc(pc),
      .halted(halted), .err(err)
   );

   crypto_ctrl_core #(.DATA_W(8), .ADDR_W(4), .ALU_TIMEOUT(4)) u_dut_w (
      .clk(clk), .rst(w_rst), .c_data_in(w_data_in), .c_addr_in(w_addr_in),
      .manual_we(w_manual_we), .alu_res_in(8'h00), .alu_done(1'b0),
      .alu_start(w_alu_start), .alu_mode(w_alu_mode), .c_out_A(w_A),
      .c_out_B(w_B), .c_out_C(w_C), .c_we(w_c_we),
      .c_addr_out(w_addr_out), .c_data_out(w_data_out), .pc(w_pc),
      .halted(w_halted), .err(w_err)
   );

   always #5 clk = ~clk;

   assign alu_res_in = alu_xor ? (c_out_A ^ c_out_B) : alu_const;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ALU model: done is raised on WAIT cycle alu_delay after a launch.
   always @(negedge clk) begin
      if (alu_start) begin
         wcnt = 0;
      end else if (wcnt >= 0) begin
         wcnt = wcnt + 1;
      end
      alu_done = (wcnt == alu_delay);
   end

   // Scoreboard: pop expected writes and launch modes as the DUT produces them.
   always @(negedge clk) begin
      wr_t e;
      logic m;
      if (c_we) begin
         if (wr_q.size() == 0) begin
            check_val("sb_wr_unexpected", 32'(wr_q.size()), 32'd1);
         end else begin
            e = wr_q.pop_front();
            check_val("sb_wr", 32'({c_addr_out, c_data_out}), 32'(e));
         end
      end
      if (alu_start) begin
         if (mode_q.size() == 0) begin
            check_val("sb_start_unexpected", 32'(mode_q.size()), 32'd1);
         end else begin
            m = mode_q.pop_front();
            check_val("sb_mode", 32'(alu_mode), 32'(m));
         end
      end
   end

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Reset, load prog_q from address 0, reset again, check reset state.
   // Returns on the negedge after the final reset edge with rst released.
   task automatic load_and_reset();
      @(negedge clk);
      rst       = 1'b1;
      manual_we = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < prog_q.size(); i++) begin
         manual_we = 1'b1;
         c_addr_in = 8'(i);
         c_data_in = prog_q[i];
         @(negedge clk);
      end
      manual_we = 1'b0;
      rst       = 1'b1;
      @(negedge clk);
      check_val("rst_pc", 32'(pc), 32'h0);
      check_val("rst_regs", 32'({c_out_A, c_out_B, c_out_C}), 32'h0);
      check_val("rst_wr", 32'({c_addr_out, c_data_out}), 32'h0);
      check_val("rst_flags", 32'({c_we, alu_start, alu_mode, halted, err}), 32'h0);
      rst = 1'b0;
   endtask

   task automatic wait_halt(input int max_cyc);
      int n = 0;
      while (!halted && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      check_val("halt_reached", 32'(halted), 32'h1);
   endtask

   task automatic drain_check(input string tag);
      check_val(tag, 32'(wr_q.size() + mode_q.size()), 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Basic program: LDA 1F, LDB 34, ENC, HALT; done on WAIT cycle 3.
      prog_q    = '{8'h20, 8'h1F, 8'h30, 8'h34, 8'h60, 8'hF0};
      alu_xor   = 1'b1;
      alu_delay = 3;
      mode_q.push_back(1'b0);
      load_and_reset();
      run(2);
      check_val("basic_A_c2", 32'(c_out_A), 32'h1F);
      check_val("basic_pc_c2", 32'(pc), 32'h02);
      run(2);
      check_val("basic_B_c4", 32'(c_out_B), 32'h34);
      wait_halt(20);
      check_val("basic_C", 32'(c_out_C), 32'h2B);
      check_val("basic_err", 32'(err), 32'h0);
      check_val("basic_pc_end", 32'(pc), 32'h06);
      drain_check("basic_drain");

      // STI/STC: STI 80,99; LDA 05; LDB 06; ENC -> AA; STC 81; HALT.
      prog_q    = '{8'h10, 8'h80, 8'h99, 8'h20, 8'h05, 8'h30, 8'h06,
                    8'h60, 8'h80, 8'h81, 8'hF0};
      alu_xor   = 1'b0;
      alu_const = 8'hAA;
      alu_delay = 2;
      wr_q.push_back('{addr: 8'h80, data: 8'h99});
      wr_q.push_back('{addr: 8'h81, data: 8'hAA});
      mode_q.push_back(1'b0);
      load_and_reset();
      wait_halt(40);
      check_val("sti_mem80", 32'(u_dut.mem[8'h80]), 32'h99);
      check_val("stc_mem81", 32'(u_dut.mem[8'h81]), 32'hAA);
      check_val("stc_last_wr", 32'({c_addr_out, c_data_out}), 32'h81AA);
      check_val("stc_C", 32'(c_out_C), 32'hAA);
      check_val("stc_err", 32'(err), 32'h0);
      drain_check("stc_drain");

      // Timeout: done never comes; HALT after WAIT cycle 4.
      prog_q    = '{8'h20, 8'h01, 8'h30, 8'h02, 8'h60, 8'hF0};
      alu_xor   = 1'b1;
      alu_delay = 9999;
      mode_q.push_back(1'b0);
      load_and_reset();
      run(9);
      check_val("to_wait4_halted", 32'(halted), 32'h0);
      run(1);
      check_val("to_halted", 32'(halted), 32'h1);
      check_val("to_err", 32'(err), 32'h1);
      check_val("to_C", 32'(c_out_C), 32'h0);
      check_val("to_pc", 32'(pc), 32'h05);
      drain_check("to_drain");

      // Boundary: DEC with done on WAIT cycle 4 is accepted.
      prog_q    = '{8'h20, 8'h01, 8'h30, 8'h02, 8'h70, 8'hF0};
      alu_delay = 4;
      mode_q.push_back(1'b1);
      load_and_reset();
      run(10);
      check_val("tb4_C", 32'(c_out_C), 32'h03);
      check_val("tb4_halted", 32'(halted), 32'h0);
      wait_halt(10);
      check_val("tb4_err", 32'(err), 32'h0);
      check_val("tb4_pc", 32'(pc), 32'h06);
      drain_check("tb4_drain");

      // Illegal opcode, then a manual write while halted.
      prog_q = '{8'h50};
      load_and_reset();
      run(1);
      check_val("ill_flags", 32'({halted, err}), 32'h3);
      check_val("ill_pc", 32'(pc), 32'h01);
      manual_we = 1'b1;
      c_addr_in = 8'hF0;
      c_data_in = 8'h5A;
      run(1);
      manual_we = 1'b0;
      run(2);
      check_val("ill_manual_mem", 32'(u_dut.mem[8'hF0]), 32'h5A);
      check_val("ill_pc_frozen", 32'({pc, halted}), 32'h03);

      // Manual stall for 3 cycles mid-program.
      prog_q    = '{8'h20, 8'h0A, 8'h30, 8'h0B, 8'h60, 8'hF0};
      alu_delay = 1;
      mode_q.push_back(1'b0);
      load_and_reset();
      run(2);
      check_val("stall_A", 32'(c_out_A), 32'h0A);
      manual_we = 1'b1;
      c_addr_in = 8'hF1;
      c_data_in = 8'hC3;
      run(3);
      manual_we = 1'b0;
      check_val("stall_pc", 32'(pc), 32'h02);
      check_val("stall_regs", 32'({c_out_A, c_out_B, c_out_C}), 32'h0A0000);
      check_val("stall_mem", 32'(u_dut.mem[8'hF1]), 32'hC3);
      wait_halt(30);
      check_val("stall_B", 32'(c_out_B), 32'h0B);
      check_val("stall_C", 32'(c_out_C), 32'h01);
      check_val("stall_end", 32'({pc, err}), 32'h0C);
      drain_check("stall_drain");

      // Reset during WAIT; late done must be ignored.
      prog_q    = '{8'h20, 8'h11, 8'h30, 8'h22, 8'h60, 8'hF0};
      alu_delay = 2;
      mode_q.push_back(1'b0);
      mode_q.push_back(1'b0);
      load_and_reset();
      run(6);
      rst = 1'b1;
      run(1);
      check_val("rw_pc", 32'(pc), 32'h0);
      check_val("rw_C", 32'(c_out_C), 32'h0);
      check_val("rw_flags", 32'({halted, err}), 32'h0);
      rst = 1'b0;
      run(1);
      check_val("rw_C_late_done", 32'(c_out_C), 32'h0);
      check_val("rw_pc_fetch", 32'(pc), 32'h01);
      wait_halt(30);
      check_val("rw_C_rerun", 32'(c_out_C), 32'h33);
      drain_check("rw_drain");

      // Wrap on the ADDR_W=4 instance: LDA at 15, immediate at 0.
      @(negedge clk);
      w_rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         w_manual_we = 1'b1;
         w_addr_in   = 4'(i);
         w_data_in   = (i == 0) ? 8'h3C : ((i == 15) ? 8'h20 : 8'h00);
         @(negedge clk);
      end
      w_manual_we = 1'b0;
      w_rst       = 1'b1;
      @(negedge clk);
      w_rst = 1'b0;
      run(16);
      check_val("wrap_pc0", 32'(w_pc), 32'h0);
      run(1);
      check_val("wrap_A", 32'(w_A), 32'h3C);
      check_val("wrap_pc1", 32'(w_pc), 32'h1);
      check_val("wrap_BC", 32'({w_B, w_C}), 32'h0);
      check_val("wrap_wr", 32'({w_addr_out, w_data_out}), 32'h0);
      check_val("wrap_flags", 32'({w_alu_start, w_alu_mode, w_c_we, w_halted, w_err}), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
